// File: rtl/stream_response_checker_pkg.sv
// Shared types and constants for the stream response checker.
package stream_check_pkg;

   // Session state. PASS and FAIL are terminal until reset.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

   // fail_step value that marks a timeout instead of a data mismatch.
   localparam logic [31:0] TIMEOUT_STEP = 32'hFFFF_FFFF;

   // Width of the compare counter.
   localparam int COUNT_W = 16;

endpackage

// File: rtl/stream_response_checker_delay_line.sv
// Fixed-latency delay line for {valid, data} beats. Clearing it drops every
// in-flight entry. With LATENCY = 0 the input is passed straight through.
module stream_delay_line #(
   parameter int DW      = 2,
   parameter int LATENCY = 1
) (
   input  logic          clock,
   input  logic          clear_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);

   generate
      if (LATENCY == 0) begin : g_pass
         // No storage; clock and clear have nothing to act on.
         logic unused_ok;
         assign unused_ok = clock ^ clear_i;
         assign q_o       = d_i;
      end else begin : g_shift
         logic [DW-1:0] stage_q [LATENCY];

         // Shift one stage per cycle, or wipe the whole line on clear.
         always_ff @(posedge clock) begin
            if (clear_i) begin
               for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/stream_response_checker.sv
// Receive-side checker: delays the stimulus stream by the DUT latency and
// compares it against the DUT response, treating the DUT as an identity.
// Reports a sticky pass/fail verdict and captures the first mismatch.
//
// Stream handshake: a_valid_i qualifies a_i for a single cycle. There is no
// ready/backpressure; every valid beat is consumed in the cycle it appears.
// y_i is only sampled in cycles whose delayed beat is valid, so y_i may be
// undriven or X at all other times.
module stream_response_checker
   import stream_check_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int LATENCY    = 1,
   parameter int NUM_CHECKS = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_i,
   input  logic               a_valid_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   y_i,
   output logic               done_o,
   output logic               pass_o,
   output logic               fail_o,
   output logic [31:0]        fail_step_o,
   output logic [WIDTH-1:0]   fail_expected_o,
   output logic [WIDTH-1:0]   fail_actual_o,
   output logic [COUNT_W-1:0] check_count_o,
   output logic [1:0]         state_o
);

   localparam logic [COUNT_W-1:0] NUM_C   = COUNT_W'(NUM_CHECKS);
   localparam logic [31:0]        TO_LAST = 32'(TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]          cyc_q, cyc_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic [31:0]          step_q, step_d;
   logic [WIDTH-1:0]     fexp_q, fexp_d;
   logic [WIDTH-1:0]     fact_q, fact_d;

   logic [WIDTH:0]       tap;
   logic                 exp_valid;
   logic [WIDTH-1:0]     exp_data;
   logic                 line_clear;
   logic                 cmp_en;
   logic                 mismatch;
   logic [COUNT_W-1:0]   cnt_inc;

   // The line only fills while a session runs; outside RUN it stays empty so
   // no beat from before the session can ever reach the comparator.
   assign line_clear = reset || (state_q != RUN);

   stream_delay_line #(
      .DW      (WIDTH + 1),
      .LATENCY (LATENCY)
   ) u_delay (
      .clock   (clock),
      .clear_i (line_clear),
      .d_i     ({a_valid_i, a_i}),
      .q_o     (tap)
   );

   assign exp_valid = tap[WIDTH];
   assign exp_data  = tap[WIDTH-1:0];
   assign cmp_en    = (state_q == RUN) && exp_valid;
   assign mismatch  = cmp_en && (y_i != exp_data);
   assign cnt_inc   = (cnt_q == NUM_C) ? cnt_q : cnt_q + 16'd1;

   // State and result registers; reset returns everything to an empty IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cyc_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         step_q  <= '0;
         fexp_q  <= '0;
         fact_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         step_q  <= step_d;
         fexp_q  <= fexp_d;
         fact_q  <= fact_d;
      end
   end

   // Session control: compare, count, decide pass/fail/timeout, capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      step_d  = step_q;
      fexp_d  = fexp_q;
      fact_d  = fact_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               cyc_d   = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cyc_d = cyc_q + 32'd1;
            if (cmp_en) cnt_d = cnt_inc;
            // A mismatch outranks both a completing match and the timeout.
            if (mismatch) begin
               state_d = FAIL;
               fail_d  = 1'b1;
               done_d  = 1'b1;
               step_d  = 32'(cnt_q);
               fexp_d  = exp_data;
               fact_d  = y_i;
            end else if (cmp_en && (cnt_inc == NUM_C)) begin
               state_d = PASS;
               pass_d  = 1'b1;
               done_d  = 1'b1;
            end else if (cyc_q == TO_LAST) begin
               state_d = FAIL;
               fail_d  = 1'b1;
               done_d  = 1'b1;
               step_d  = TIMEOUT_STEP;
               fexp_d  = '0;
               fact_d  = '0;
            end
         end
         PASS, FAIL: begin
            state_d = state_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign done_o          = done_q;
   assign pass_o          = pass_q;
   assign fail_o          = fail_q;
   assign fail_step_o     = step_q;
   assign fail_expected_o = fexp_q;
   assign fail_actual_o   = fact_q;
   assign check_count_o   = cnt_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_stream_response_checker.sv
// Bench for stream_response_checker: three instances with different
// width/latency/count/timeout settings, a session-level reference model,
// a per-cycle compare process and a few hand-computed expectations.
module tb_stream_response_checker;

   localparam int NI   = 3;
   localparam int MAXC = 128;

   // Instance configurations: {WIDTH, LATENCY, NUM_CHECKS, TIMEOUT}
   //   0: 8, 3, 4, 64    1: 1, 1, 2, 16    2: 8, 0, 3, 32
   function automatic int cfg_w(int g);
      return (g == 1) ? 1 : 8;
   endfunction
   function automatic int cfg_l(int g);
      return (g == 0) ? 3 : (g == 1) ? 1 : 0;
   endfunction
   function automatic int cfg_n(int g);
      return (g == 0) ? 4 : (g == 1) ? 2 : 3;
   endfunction
   function automatic int cfg_t(int g);
      return (g == 0) ? 64 : (g == 1) ? 16 : 32;
   endfunction
   function automatic logic [7:0] mask_of(int g);
      return (cfg_w(g) >= 8) ? 8'hFF : 8'((1 << cfg_w(g)) - 1);
   endfunction
   function automatic logic [7:0] rnd(int g);
      return 8'($urandom) & mask_of(g);
   endfunction

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        start_s [NI];
   logic        av_s    [NI];
   logic [7:0]  a_s     [NI];
   logic [7:0]  y_s     [NI];
   logic        done_w  [NI];
   logic        pass_w  [NI];
   logic        fail_w  [NI];
   logic [31:0] step_w  [NI];
   logic [7:0]  fexp_w  [NI];
   logic [7:0]  fact_w  [NI];
   logic [15:0] cnt_w   [NI];
   logic [1:0]  st_w    [NI];

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         localparam int W = cfg_w(g);
         logic [W-1:0] fe;
         logic [W-1:0] fa;
         stream_response_checker #(
            .WIDTH      (W),
            .LATENCY    (cfg_l(g)),
            .NUM_CHECKS (cfg_n(g)),
            .TIMEOUT    (cfg_t(g))
         ) u_dut (
            .clock           (clock),
            .reset           (reset),
            .start_i         (start_s[g]),
            .a_valid_i       (av_s[g]),
            .a_i             (a_s[g][W-1:0]),
            .y_i             (y_s[g][W-1:0]),
            .done_o          (done_w[g]),
            .pass_o          (pass_w[g]),
            .fail_o          (fail_w[g]),
            .fail_step_o     (step_w[g]),
            .fail_expected_o (fe),
            .fail_actual_o   (fa),
            .check_count_o   (cnt_w[g]),
            .state_o         (st_w[g])
         );
         assign fexp_w[g] = 8'(fe);
         assign fact_w[g] = 8'(fa);
      end
   endgenerate

   // ---------------- reference model ----------------
   // Session view: phase 0 = waiting for start, 1 = running, 2 = verdict.
   // m_h keeps every beat of the session by RUN-cycle index; the expected
   // beat at RUN cycle k is the one offered LATENCY cycles earlier.
   int          m_phase [NI];
   int          m_k     [NI];
   int          m_cnt   [NI];
   logic        m_done  [NI];
   logic        m_pass  [NI];
   logic        m_fail  [NI];
   logic [31:0] m_step  [NI];
   logic [7:0]  m_exp   [NI];
   logic [7:0]  m_act   [NI];
   logic [8:0]  m_h     [NI][MAXC];
   logic        m_live = 1'b0;

   always @(posedge clock) begin
      for (int g = 0; g < NI; g++) begin
         int          ph, k, cnt, lat;
         logic        dn, ps, fl;
         logic [31:0] st;
         logic [7:0]  ex, ac;
         logic [8:0]  e;
         ph = m_phase[g]; k = m_k[g]; cnt = m_cnt[g]; lat = cfg_l(g);
         dn = m_done[g]; ps = m_pass[g]; fl = m_fail[g];
         st = m_step[g]; ex = m_exp[g]; ac = m_act[g];
         e  = '0;
         if (reset) begin
            ph = 0; k = 0; cnt = 0; dn = 0; ps = 0; fl = 0; st = 0; ex = 0; ac = 0;
         end else if (ph == 0) begin
            if (start_s[g]) begin
               ph = 1; k = 0; cnt = 0;
            end
         end else if (ph == 1) begin
            if (lat == 0) e = {av_s[g], a_s[g]};
            else if (k >= lat && (k - lat) < MAXC) e = m_h[g][k - lat];
            if (k < MAXC) m_h[g][k] <= {av_s[g], a_s[g]};
            if (e[8]) begin
               if (y_s[g] != e[7:0]) begin
                  fl = 1; dn = 1; st = 32'(cnt); ex = e[7:0]; ac = y_s[g]; ph = 2;
               end else if (cnt + 1 == cfg_n(g)) begin
                  ps = 1; dn = 1; ph = 2;
               end
               if (cnt < cfg_n(g)) cnt = cnt + 1;
            end
            if (ph == 1 && k == cfg_t(g) - 1) begin
               fl = 1; dn = 1; st = 32'hFFFF_FFFF; ex = 0; ac = 0; ph = 2;
            end
            k = k + 1;
         end
         m_phase[g] <= ph; m_k[g] <= k; m_cnt[g] <= cnt;
         m_done[g] <= dn; m_pass[g] <= ps; m_fail[g] <= fl;
         m_step[g] <= st; m_exp[g] <= ex; m_act[g] <= ac;
      end
      m_live <= 1'b1;
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   // Hand-computed expectations posted by the stimulus thread, consumed by
   // the compare process on the following falling edge.
   int          lit_g    [MAXC];
   int          lit_f    [MAXC];
   logic [31:0] lit_exp  [MAXC];
   string       lit_name [MAXC];
   int          lit_wr = 0;
   int          lit_rd = 0;

   function automatic logic [31:0] dut_field(int g, int f);
      case (f)
         0: return 32'(done_w[g]);
         1: return 32'(pass_w[g]);
         2: return 32'(fail_w[g]);
         3: return step_w[g];
         4: return 32'(fexp_w[g]);
         5: return 32'(fact_w[g]);
         default: return 32'(cnt_w[g]);
      endcase
   endfunction

   task automatic check(int g, string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", name, g, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (m_live) begin
         for (int g = 0; g < NI; g++) begin
            check(g, "done",          dut_field(g, 0), 32'(m_done[g]));
            check(g, "pass",          dut_field(g, 1), 32'(m_pass[g]));
            check(g, "fail",          dut_field(g, 2), 32'(m_fail[g]));
            check(g, "fail_step",     dut_field(g, 3), m_step[g]);
            check(g, "fail_expected", dut_field(g, 4), 32'(m_exp[g]));
            check(g, "fail_actual",   dut_field(g, 5), 32'(m_act[g]));
            check(g, "check_count",   dut_field(g, 6), 32'(m_cnt[g]));
         end
      end
      while (lit_rd < lit_wr) begin
         check(lit_g[lit_rd], lit_name[lit_rd],
               dut_field(lit_g[lit_rd], lit_f[lit_rd]), lit_exp[lit_rd]);
         lit_rd++;
      end
   end

   // ---------------- driver tasks ----------------
   int         drv_n   [NI];
   int         drv_cmp [NI];
   logic [8:0] drv_h   [NI][MAXC];

   task automatic expect_lit(int g, int f, logic [31:0] exp, string name);
      if (lit_wr < MAXC) begin
         lit_g[lit_wr]    = g;
         lit_f[lit_wr]    = f;
         lit_exp[lit_wr]  = exp;
         lit_name[lit_wr] = name;
         lit_wr++;
      end
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      for (int g = 0; g < NI; g++) begin
         start_s[g] = 1'b0;
         av_s[g]    = 1'($urandom_range(0, 1));
         a_s[g]     = rnd(g);
         y_s[g]     = rnd(g);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int g = 0; g < NI; g++) av_s[g] = 1'b0;
   endtask

   // One start cycle; a_valid is randomised to show it is ignored in IDLE.
   task automatic start_session(int g);
      start_s[g] = 1'b1;
      av_s[g]    = 1'($urandom_range(0, 1));
      a_s[g]     = rnd(g);
      y_s[g]     = rnd(g);
      @(posedge clock); #1;
      start_s[g] = 1'b0;
      drv_n[g]   = 0;
      drv_cmp[g] = 0;
   endtask

   // One RUN cycle: offer a beat and act as an identity DUT with the
   // configured latency. The compare with ordinal 'bad' gets bit 0 flipped.
   // When no valid beat is due, y carries junk.
   task automatic drive(int g, bit av, logic [7:0] a, int bad, bit st = 1'b0);
      int         src;
      logic [8:0] e;
      a          = a & mask_of(g);
      start_s[g] = st;
      av_s[g]    = av;
      a_s[g]     = a;
      if (drv_n[g] < MAXC) drv_h[g][drv_n[g]] = {av, a};
      src = drv_n[g] - cfg_l(g);
      e   = (src >= 0 && src < MAXC) ? drv_h[g][src] : 9'd0;
      if (e[8]) begin
         y_s[g] = e[7:0] ^ ((drv_cmp[g] == bad) ? 8'd1 : 8'd0);
         drv_cmp[g]++;
      end else begin
         y_s[g] = rnd(g);
      end
      drv_n[g]++;
      @(posedge clock); #1;
      start_s[g] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] last_a;
      logic [7:0] pat_a [6];
      bit         pat_v [6];
      pat_a = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h00, 8'h44};
      pat_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      reset = 1'b1;
      for (int g = 0; g < NI; g++) begin
         start_s[g] = 1'b0; av_s[g] = 1'b0; a_s[g] = '0; y_s[g] = '0;
         drv_n[g] = 0; drv_cmp[g] = 0;
      end
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      expect_lit(0, 0, 32'd0, "reset_done");
      expect_lit(0, 3, 32'd0, "reset_fail_step");
      expect_lit(1, 6, 32'd0, "reset_check_count");

      // Width 1, latency 1: two matching compares pass.
      reset_pulse(); start_session(1);
      drive(1, 1'b1, 8'd1, -1); drive(1, 1'b1, 8'd1, -1); drive(1, 1'b0, 8'd0, -1);
      expect_lit(1, 1, 32'd1, "w1_pass");
      expect_lit(1, 0, 32'd1, "w1_done");
      expect_lit(1, 2, 32'd0, "w1_no_fail");
      expect_lit(1, 6, 32'd2, "w1_count");

      // Same, second response forced to 0.
      reset_pulse(); start_session(1);
      drive(1, 1'b1, 8'd1, 1); drive(1, 1'b1, 8'd1, 1); drive(1, 1'b0, 8'd0, 1);
      expect_lit(1, 2, 32'd1, "w1_mis_fail");
      expect_lit(1, 3, 32'd1, "w1_mis_step");
      expect_lit(1, 4, 32'd1, "w1_mis_expected");
      expect_lit(1, 5, 32'd0, "w1_mis_actual");
      expect_lit(1, 1, 32'd0, "w1_mis_no_pass");

      // Timeout 16 with no valid beats.
      reset_pulse(); start_session(1);
      repeat (15) drive(1, 1'b0, rnd(1), -1);
      expect_lit(1, 2, 32'd0, "timeout_not_yet");
      drive(1, 1'b0, rnd(1), -1);
      expect_lit(1, 2, 32'd1, "timeout_fail");
      expect_lit(1, 3, 32'hFFFF_FFFF, "timeout_step");
      expect_lit(1, 4, 32'd0, "timeout_expected");

      // Width 8, latency 3, beats with gaps.
      reset_pulse(); start_session(0);
      for (int i = 0; i < 6; i++) drive(0, pat_v[i], pat_a[i], -1);
      drive(0, 1'b0, 8'h00, -1); drive(0, 1'b0, 8'h00, -1);
      expect_lit(0, 1, 32'd0, "gap_pass_not_yet");
      expect_lit(0, 6, 32'd3, "gap_count_3");
      drive(0, 1'b0, 8'h00, -1);
      expect_lit(0, 1, 32'd1, "gap_pass");
      expect_lit(0, 6, 32'd4, "gap_count_4");

      // Reset mid-run after one compare, then a clean session.
      reset_pulse(); start_session(0);
      repeat (4) drive(0, 1'b1, rnd(0), -1);
      expect_lit(0, 6, 32'd1, "midrun_count_1");
      av_s[0] = 1'b1;
      reset_pulse();
      expect_lit(0, 6, 32'd0, "midrun_count_cleared");
      start_session(0);
      repeat (4) drive(0, 1'b1, rnd(0), -1);
      repeat (3) drive(0, 1'b0, rnd(0), -1);
      expect_lit(0, 1, 32'd1, "restart_pass");
      expect_lit(0, 6, 32'd4, "restart_count");

      // Latency 0, mismatch on the final compare.
      reset_pulse(); start_session(2);
      last_a = 8'h00;
      for (int i = 0; i < 3; i++) begin
         last_a = rnd(2);
         drive(2, 1'b1, last_a, 2);
      end
      expect_lit(2, 2, 32'd1, "lat0_fail");
      expect_lit(2, 1, 32'd0, "lat0_no_pass");
      expect_lit(2, 3, 32'd2, "lat0_step");
      expect_lit(2, 4, 32'(last_a), "lat0_expected");
      expect_lit(2, 5, 32'(last_a ^ 8'd1), "lat0_actual");

      // Randomised sessions on all instances, checked by the model.
      for (int r = 0; r < 36; r++) begin
         int g, bad, dens, ncyc;
         g    = r % NI;
         bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, cfg_n(g) - 1)) : -1;
         dens = $urandom_range(0, 4);
         ncyc = $urandom_range(4, cfg_t(g) + 6);
         reset_pulse(); start_session(g);
         for (int i = 0; i < ncyc; i++) begin
            drive(g, ($urandom_range(1, 4) <= dens), rnd(g), bad,
                  ($urandom_range(0, 15) == 0));
         end
      end

      repeat (2) @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

endmodule
